// File: rtl/x2050_lmv_seq_if.sv
// x2050_lmv_seq_if -- request/source/result bundle for the U-register move sequencer.
// The master side issues moves and supplies source bytes; the slave side
// (x2050_lmv_seq) returns the U byte, strobes, and status.
interface x2050_lmv_seq_if #(
    parameter int WIDTH  = 8,
    parameter int NSRC   = 16,
    parameter int LBYTES = 4
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int PW = (LBYTES > 1) ? $clog2(LBYTES) : 1;

    logic                     i_start;
    logic [SW-1:0]            i_sel;
    logic                     i_walk;
    logic [PW-1:0]            i_lb;
    logic [PW:0]              i_count;
    logic [NSRC*WIDTH-1:0]    i_src;
    logic [LBYTES*WIDTH-1:0]  i_l_reg;
    logic                     i_ext_valid;
    logic                     o_ext_ack;
    logic [WIDTH-1:0]         o_u_reg;
    logic                     o_u_valid;
    logic                     o_busy;
    logic [PW-1:0]            o_lb_ptr;
    logic                     o_u_parity;

    modport master (
        output i_start, i_sel, i_walk, i_lb, i_count, i_src, i_l_reg, i_ext_valid,
        input  o_ext_ack, o_u_reg, o_u_valid, o_busy, o_lb_ptr, o_u_parity
    );

    modport slave (
        input  i_start, i_sel, i_walk, i_lb, i_count, i_src, i_l_reg, i_ext_valid,
        output o_ext_ack, o_u_reg, o_u_valid, o_busy, o_lb_ptr, o_u_parity
    );
endinterface

// File: rtl/x2050_lmv_seq.sv
// x2050_lmv_seq -- moves one byte from a selectable source (or a walk of bytes
// from the L register) into the U register.
// Internal sources load one edge after acceptance; the external sources
// EXT_A/EXT_B wait for i_ext_valid and acknowledge the byte they consume.
// Walk mode copies L bytes starting at i_lb for i_count bytes (0 means 1),
// wrapping the byte pointer modulo LBYTES.
// Optional feature: define X2050_LMV_PARITY_EN to get a registered odd-parity
// bit tracking o_u_reg (reset value 1); otherwise o_u_parity is tied to 0.
module x2050_lmv_seq #(
    parameter int WIDTH  = 8,
    parameter int NSRC   = 16,
    parameter int LBYTES = 4,
    parameter int EXT_A  = 3,
    parameter int EXT_B  = 11
) (
    input  logic               i_clk,
    input  logic               i_reset,
    x2050_lmv_seq_if.slave     bus
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int PW = (LBYTES > 1) ? $clog2(LBYTES) : 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(LBYTES - 1);
    localparam logic [PW:0]   REM_ONE  = (PW + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXT_WAIT = 2'd1,
        ST_WALK     = 2'd2,
        ST_LOAD     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW:0]       rem_q, rem_d;
    logic [WIDTH-1:0]  u_reg_q, u_reg_d;
    logic              u_valid_q, u_valid_d;
    logic              ext_ack_q, ext_ack_d;
    logic              busy_q, busy_d;

    // True when the index names one of the handshaked external sources.
    function automatic logic is_ext(input logic [SW-1:0] s);
        return (int'(s) == EXT_A) || (int'(s) == EXT_B);
    endfunction

    // Source mux; index 0 and out-of-range indices read as zero.
    function automatic logic [WIDTH-1:0] pick_src(input logic [NSRC*WIDTH-1:0] src,
                                                   input logic [SW-1:0] s);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int k = 0; k < NSRC; k++) begin
            if ((k != 0) && (int'(s) == k)) begin
                r = src[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // L-register byte select; byte 0 is the most significant slice.
    function automatic logic [WIDTH-1:0] l_byte(input logic [LBYTES*WIDTH-1:0] l,
                                                 input logic [PW-1:0] p);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int k = 0; k < LBYTES; k++) begin
            if (int'(p) == k) begin
                r = l[(LBYTES-1-k)*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // Next-state and next-output computation for the move sequencer.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        u_reg_d   = u_reg_q;
        u_valid_d = 1'b0;
        ext_ack_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    sel_d = bus.i_sel;
                    if (bus.i_walk) begin
                        state_d = ST_WALK;
                        ptr_d   = bus.i_lb;
                        rem_d   = (bus.i_count == {(PW+1){1'b0}}) ? REM_ONE : bus.i_count;
                    end else if (is_ext(bus.i_sel)) begin
                        state_d = ST_EXT_WAIT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                u_reg_d   = pick_src(bus.i_src, sel_q);
                u_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_EXT_WAIT: begin
                if (bus.i_ext_valid) begin
                    u_reg_d   = pick_src(bus.i_src, sel_q);
                    u_valid_d = 1'b1;
                    ext_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_EXT_WAIT;
                end
            end
            ST_WALK: begin
                u_reg_d   = l_byte(bus.i_l_reg, ptr_q);
                u_valid_d = 1'b1;
                ptr_d     = (ptr_q == PTR_LAST) ? {PW{1'b0}} : (ptr_q + PTR_ONE);
                rem_d     = rem_q - REM_ONE;
                if (rem_q <= REM_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WALK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs; reset aborts any move in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= {SW{1'b0}};
            ptr_q     <= {PW{1'b0}};
            rem_q     <= {(PW+1){1'b0}};
            u_reg_q   <= {WIDTH{1'b0}};
            u_valid_q <= 1'b0;
            ext_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            u_reg_q   <= u_reg_d;
            u_valid_q <= u_valid_d;
            ext_ack_q <= ext_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_u_reg   = u_reg_q;
    assign bus.o_u_valid = u_valid_q;
    assign bus.o_ext_ack = ext_ack_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_lb_ptr  = ptr_q;

`ifdef X2050_LMV_PARITY_EN
    logic parity_q, parity_d;

    // Odd parity: the bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [WIDTH-1:0] b);
        return ~(^b);
    endfunction

    // Parity follows whatever byte U will hold after this edge.
    always_comb begin
        parity_d = odd_parity(u_reg_d);
    end

    // Parity register; the all-zero reset byte has odd parity 1.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            parity_q <= 1'b1;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.o_u_parity = parity_q;
`else
    assign bus.o_u_parity = 1'b0;
`endif

endmodule

// File: tb/tb_x2050_lmv_seq.sv
// Directed bench for x2050_lmv_seq: single loads, external handshake, walks,
// ignored restarts, asynchronous reset mid-walk, and the parity output.
module tb_x2050_lmv_seq;
    logic i_clk;
    logic i_reset;
    int   n_vec;
    int   n_err;

    x2050_lmv_seq_if bus ();

    x2050_lmv_seq dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_par;
`ifdef X2050_LMV_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        #2;
        n_vec++; if (bus.o_u_reg !== 8'h00) begin n_err++; $display("FAIL rst_u_reg: got %h want 00", bus.o_u_reg); end
        n_vec++; if (bus.o_u_valid !== 1'b0) begin n_err++; $display("FAIL rst_u_valid: got %b want 0", bus.o_u_valid); end
        n_vec++; if (bus.o_ext_ack !== 1'b0) begin n_err++; $display("FAIL rst_ext_ack: got %b want 0", bus.o_ext_ack); end
        n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
        n_vec++; if (bus.o_lb_ptr !== 2'd0) begin n_err++; $display("FAIL rst_lb_ptr: got %0d want 0", bus.o_lb_ptr); end
        n_vec++; if (bus.o_u_parity !== exp_par) begin n_err++; $display("FAIL rst_parity: got %b want %b", bus.o_u_parity, exp_par); end
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        n_vec++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_after_release: busy got %b want 0", bus.o_busy); end
    endtask

    // Internal load: latency two edges, selection frozen at acceptance.
    task automatic test_load();
        bus.i_src[2*8 +: 8] = 8'hA5;
        bus.i_src[5*8 +: 8] = 8'h77;
        bus.i_start = 1'b1; bus.i_sel = 4'd2; bus.i_walk = 1'b0;
        tick();
        bus.i_start = 1'b0; bus.i_sel = 4'd5;
        n_vec++; if (bus.o_busy !== 1'b1 || bus.o_u_valid !== 1'b0) begin n_err++; $display("FAIL load_edge1: busy/valid got %b%b want 10", bus.o_busy, bus.o_u_valid); end
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b want 1", bus.o_u_valid); end
        n_vec++; if (bus.o_u_reg !== 8'hA5) begin n_err++; $display("FAIL load_data: got %h want a5", bus.o_u_reg); end
        n_vec++; if (bus.o_ext_ack !== 1'b0) begin n_err++; $display("FAIL load_no_ack: got %b want 0", bus.o_ext_ack); end
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL load_done: valid/busy got %b%b want 00", bus.o_u_valid, bus.o_busy); end
        n_vec++; if (bus.o_u_reg !== 8'hA5) begin n_err++; $display("FAIL load_hold: got %h want a5", bus.o_u_reg); end
        // Index 0 always reads as zero even with nonzero slice 0.
        bus.i_src[7:0] = 8'hFF;
        bus.i_start = 1'b1; bus.i_sel = 4'd0;
        tick();
        bus.i_start = 1'b0;
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b1 || bus.o_u_reg !== 8'h00) begin n_err++; $display("FAIL load_sel0: valid/data got %b %h want 1 00", bus.o_u_valid, bus.o_u_reg); end
        // Top index is an ordinary internal source.
        bus.i_src[15*8 +: 8] = 8'hC3;
        bus.i_start = 1'b1; bus.i_sel = 4'd15;
        tick();
        bus.i_start = 1'b0;
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b1 || bus.o_u_reg !== 8'hC3) begin n_err++; $display("FAIL load_sel15: valid/data got %b %h want 1 c3", bus.o_u_valid, bus.o_u_reg); end
        tick();
    endtask

    // External source: waits for valid, ack and valid together once.
    task automatic test_ext();
        int n_ack;
        n_ack = 0;
        bus.i_src[3*8 +: 8] = 8'h3C;
        bus.i_ext_valid = 1'b0;
        bus.i_start = 1'b1; bus.i_sel = 4'd3; bus.i_walk = 1'b0;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.o_busy !== 1'b1 || bus.o_u_valid !== 1'b0 || bus.o_ext_ack !== 1'b0) begin n_err++; $display("FAIL ext_wait[%0d]: busy/valid/ack got %b%b%b want 100", i, bus.o_busy, bus.o_u_valid, bus.o_ext_ack); end
            tick();
        end
        bus.i_ext_valid = 1'b1;
        tick();
        bus.i_ext_valid = 1'b0;
        n_vec++; if (bus.o_ext_ack !== 1'b1 || bus.o_u_valid !== 1'b1) begin n_err++; $display("FAIL ext_done: ack/valid got %b%b want 11", bus.o_ext_ack, bus.o_u_valid); end
        n_vec++; if (bus.o_u_reg !== 8'h3C) begin n_err++; $display("FAIL ext_data: got %h want 3c", bus.o_u_reg); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.o_ext_ack === 1'b1) n_ack++;
        end
        n_vec++; if (n_ack != 0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL ext_after: extra acks %0d busy %b want 0 0", n_ack, bus.o_busy); end
        // EXT_B with valid already high completes on the first wait edge.
        bus.i_src[11*8 +: 8] = 8'h5A;
        bus.i_ext_valid = 1'b1;
        bus.i_start = 1'b1; bus.i_sel = 4'd11;
        tick();
        bus.i_start = 1'b0;
        n_vec++; if (bus.o_ext_ack !== 1'b0 || bus.o_busy !== 1'b1) begin n_err++; $display("FAIL extb_entry: ack/busy got %b%b want 01", bus.o_ext_ack, bus.o_busy); end
        tick();
        bus.i_ext_valid = 1'b0;
        n_vec++; if (bus.o_ext_ack !== 1'b1 || bus.o_u_valid !== 1'b1 || bus.o_u_reg !== 8'h5A) begin n_err++; $display("FAIL extb_done: ack/valid/data got %b%b %h want 11 5a", bus.o_ext_ack, bus.o_u_valid, bus.o_u_reg); end
        tick();
    endtask

    // Walk with wrap: lb=2 count=5 over 11223344.
    task automatic test_walk();
        logic [7:0] exp_b [5];
        logic [1:0] exp_p [5];
        exp_b = '{8'h33, 8'h44, 8'h11, 8'h22, 8'h33};
        exp_p = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        bus.i_l_reg = 32'h11223344;
        bus.i_start = 1'b1; bus.i_walk = 1'b1; bus.i_lb = 2'd2; bus.i_count = 3'd5;
        tick();
        bus.i_start = 1'b0; bus.i_walk = 1'b0; bus.i_lb = 2'd0; bus.i_count = 3'd1;
        n_vec++; if (bus.o_busy !== 1'b1 || bus.o_u_valid !== 1'b0 || bus.o_lb_ptr !== 2'd2) begin n_err++; $display("FAIL walk_entry: busy/valid/ptr got %b%b %0d want 10 2", bus.o_busy, bus.o_u_valid, bus.o_lb_ptr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (bus.o_u_valid !== 1'b1 || bus.o_u_reg !== exp_b[i] || bus.o_lb_ptr !== exp_p[i]) begin n_err++; $display("FAIL walk_byte[%0d]: valid/data/ptr got %b %h %0d want 1 %h %0d", i, bus.o_u_valid, bus.o_u_reg, bus.o_lb_ptr, exp_b[i], exp_p[i]); end
        end
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_lb_ptr !== 2'd3) begin n_err++; $display("FAIL walk_end: valid/busy/ptr got %b%b %0d want 00 3", bus.o_u_valid, bus.o_busy, bus.o_lb_ptr); end
    endtask

    // Count 0 gives one byte; a start during a walk is ignored.
    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        bus.i_start = 1'b1; bus.i_walk = 1'b1; bus.i_lb = 2'd1; bus.i_count = 3'd0;
        tick();
        bus.i_start = 1'b0;
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b1 || bus.o_u_reg !== 8'h22 || bus.o_lb_ptr !== 2'd2) begin n_err++; $display("FAIL count0_byte: valid/data/ptr got %b %h %0d want 1 22 2", bus.o_u_valid, bus.o_u_reg, bus.o_lb_ptr); end
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL count0_end: valid/busy got %b%b want 00", bus.o_u_valid, bus.o_busy); end
        bus.i_start = 1'b1; bus.i_walk = 1'b1; bus.i_lb = 2'd0; bus.i_count = 3'd3;
        tick();
        bus.i_walk = 1'b0; bus.i_sel = 4'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.o_u_valid !== 1'b1 || bus.o_u_reg !== exp_b[i]) begin n_err++; $display("FAIL restart_byte[%0d]: valid/data got %b %h want 1 %h", i, bus.o_u_valid, bus.o_u_reg, exp_b[i]); end
        end
        bus.i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.o_u_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL restart_ignored[%0d]: valid/busy got %b%b want 00", i, bus.o_u_valid, bus.o_busy); end
        end
    endtask

    // Asynchronous reset after two walk bytes clears everything at once.
    task automatic test_reset_mid_walk();
        bus.i_start = 1'b1; bus.i_walk = 1'b1; bus.i_lb = 2'd0; bus.i_count = 3'd4;
        tick();
        bus.i_start = 1'b0; bus.i_walk = 1'b0;
        tick();
        tick();
        n_vec++; if (bus.o_u_valid !== 1'b1 || bus.o_u_reg !== 8'h22) begin n_err++; $display("FAIL midrst_pre: valid/data got %b %h want 1 22", bus.o_u_valid, bus.o_u_reg); end
        #2;
        i_reset = 1'b0;
        #1;
        n_vec++; if (bus.o_u_reg !== 8'h00 || bus.o_u_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_lb_ptr !== 2'd0 || bus.o_ext_ack !== 1'b0) begin n_err++; $display("FAIL midrst_async: data/valid/busy/ptr/ack got %h %b%b %0d %b want 00 00 0 0", bus.o_u_reg, bus.o_u_valid, bus.o_busy, bus.o_lb_ptr, bus.o_ext_ack); end
        tick();
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (bus.o_u_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_after[%0d]: valid/busy got %b%b want 00", i, bus.o_u_valid, bus.o_busy); end
        end
    endtask

    // Parity of loaded bytes 00 and 01 (tied low when the feature is off).
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       exp_p [2];
        vals = '{8'h00, 8'h01};
`ifdef X2050_LMV_PARITY_EN
        exp_p = '{1'b1, 1'b0};
`else
        exp_p = '{1'b0, 1'b0};
`endif
        for (int i = 0; i < 2; i++) begin
            bus.i_src[2*8 +: 8] = vals[i];
            bus.i_start = 1'b1; bus.i_sel = 4'd2; bus.i_walk = 1'b0;
            tick();
            bus.i_start = 1'b0;
            tick();
            n_vec++; if (bus.o_u_reg !== vals[i] || bus.o_u_parity !== exp_p[i]) begin n_err++; $display("FAIL parity[%0d]: data/parity got %h %b want %h %b", i, bus.o_u_reg, bus.o_u_parity, vals[i], exp_p[i]); end
        end
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        i_reset = 1'b0;
        bus.i_start = 1'b0;
        bus.i_sel = 4'd0;
        bus.i_walk = 1'b0;
        bus.i_lb = 2'd0;
        bus.i_count = 3'd0;
        bus.i_src = '0;
        bus.i_l_reg = 32'h0;
        bus.i_ext_valid = 1'b0;
        test_reset();
        test_load();
        test_ext();
        test_walk();
        test_back_to_back();
        test_reset_mid_walk();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/x2050_lmv_seq.md
X2050_LMV_SEQ -- requirements
Module: x2050_lmv_seq

Interface
REQ-001 Parameter WIDTH, default 8: byte width of every source and of U.
REQ-002 Parameter NSRC, default 16: number of selectable sources; select width SW = clog2(NSRC).
REQ-003 Parameter LBYTES, default 4: bytes in the L register for walk mode; pointer width PW = clog2(LBYTES).
REQ-004 Parameter EXT_A, default 3, and EXT_B, default 11: source indices treated as external (DD, MPX buffer) and requiring a handshake.
REQ-005 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  one-cycle request to begin a move; accepted only in IDLE.
REQ-008 i_sel  in  SW  source index, captured on an accepted i_start.
REQ-009 i_walk  in  1  walk mode, captured on an accepted i_start.
REQ-010 i_lb  in  PW  walk start byte pointer, captured on an accepted i_start.
REQ-011 i_count  in  PW+1  walk byte count, captured on an accepted i_start; 0 is treated as 1.
REQ-012 i_src  in  NSRC*WIDTH  flattened sources; slice k = bits [k*WIDTH +: WIDTH]; slice 0 is ignored and reads as zero.
REQ-013 i_l_reg  in  LBYTES*WIDTH  L register; byte 0 is the most significant slice.
REQ-014 i_ext_valid  in  1  external source data valid.
REQ-015 o_ext_ack  out  1  one-cycle acknowledge of an external byte (replaces dd/xtr sample).
REQ-016 o_u_reg  out  WIDTH  registered U byte.
REQ-017 o_u_valid  out  1  one-cycle strobe: o_u_reg updated this cycle.
REQ-018 o_busy  out  1  high in every state except IDLE.
REQ-019 o_lb_ptr  out  PW  current walk pointer.
REQ-020 o_u_parity  out  1  odd parity of o_u_reg (see Configuration).

Function
REQ-021 States are IDLE, EXT_WAIT, WALK, and LOAD.
REQ-022 IDLE with i_start, i_walk=0, and a non-external index: go to LOAD.
REQ-023 IDLE with i_start, i_walk=0, and index EXT_A or EXT_B: go to EXT_WAIT.
REQ-024 IDLE with i_start and i_walk=1: go to WALK, with pointer = i_lb and remaining = max(i_count,1).
REQ-025 LOAD: next edge o_u_reg <= selected source (0 for index 0 or index >= NSRC), o_u_valid=1, then IDLE; single-byte latency is 2 edges after i_start.
REQ-026 EXT_WAIT: hold until i_ext_valid=1. On that edge: o_u_reg <= source, o_ext_ack=1 and o_u_valid=1 in the same cycle, then IDLE.
REQ-027 EXT_WAIT when i_ext_valid is already high on entry: completes on the first EXT_WAIT edge; no extra wait.
REQ-028 WALK, each edge: o_u_reg <= L byte[pointer], o_u_valid=1, pointer <= (pointer+1) mod LBYTES, remaining decrements; at remaining=1 return to IDLE.
REQ-029 Walk wrap: pointer LBYTES-1 is followed by 0. With i_count > LBYTES, bytes repeat cyclically.
REQ-030 i_start while o_busy=1 is ignored; no queueing.
REQ-031 i_sel, i_walk, i_lb, and i_count are sampled only at acceptance; later changes have no effect on the move in progress.
REQ-032 o_u_reg holds its value between strobes.
REQ-033 o_ext_ack is never asserted outside EXT_WAIT.

Reset
REQ-034 Reset asserted asynchronously forces IDLE, o_u_reg=0, o_u_valid=0, o_ext_ack=0, o_busy=0, o_lb_ptr=0, and remaining=0, including during a move; the aborted move produces no further strobes.
REQ-035 Deassertion is followed by normal operation on the first rising edge with i_reset=1.

Configuration
REQ-036 With macro X2050_LMV_PARITY_EN defined, a registered o_u_parity equal to the odd parity of each byte loaded into o_u_reg is updated with o_u_reg; its reset value is 1.
REQ-037 Without X2050_LMV_PARITY_EN, o_u_parity is tied to 0 and no parity logic exists.

Verification
REQ-038 Default parameters; i_src slice 2 = 8'hA5; start sel=2 walk=0 -> exactly one o_u_valid 2 edges later, o_u_reg=8'hA5, o_ext_ack never high.
REQ-039 Start sel=3, i_ext_valid low for 5 cycles then high with slice 3 = 8'h3C -> o_busy high throughout; o_ext_ack and o_u_valid together once; o_u_reg=8'h3C.
REQ-040 i_l_reg=32'h11223344, walk i_lb=2, i_count=5 -> o_u_valid on 5 consecutive edges with bytes 33, 44, 11, 22, 33; o_lb_ptr ends at 3.
REQ-041 Walk count=0 -> one byte; second i_start during a walk -> ignored, no extra strobes.
REQ-042 Reset mid-walk after 2 bytes -> all outputs 0 immediately without waiting for a clock edge; no strobe after release.
REQ-043 With X2050_LMV_PARITY_EN: load 8'h00 -> o_u_parity=1; load 8'h01 -> o_u_parity=0.
